// File: rtl/load_align_unit.sv
// load_align_unit: accepts one load at a time from the MEM stage.
// It issues a word-aligned memory read and waits for the variable-latency response.
// It then extracts and extends the addressed byte, half or word for writeback.
// Misaligned or illegal loads and response timeouts are reported as one-cycle pulses.
module load_align_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [2:0]        ld_funct3,
    input  logic [4:0]        ld_rd,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic [4:0]        wb_rd,
    output logic              stall,
    output logic              exc_misaligned,
    output logic              exc_fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    // Counter value of the last WAIT cycle before the response is declared lost.
    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [4:0]        rd_q, rd_d;
    logic [7:0]        count_q, count_d;
    logic [31:0]       data_q, data_d;
    logic [4:0]        wb_rd_q, wb_rd_d;

    logic        req_legal;
    logic [1:0]  off;
    logic [1:0]  off_hi;
    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_result;

    // Split the response word into byte lanes so extraction is a lane select.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    assign off      = addr_q[1:0];
    // The wrap at off==3 is unreachable for halfwords because such loads are rejected.
    assign off_hi   = off + 2'd1;
    assign byte_sel = lane[off];
    assign half_sel = {lane[off_hi], lane[off]};

    assign mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign wb_data  = data_q;
    assign wb_rd    = wb_rd_q;

    // Classify the incoming request: legal width/offset combinations only.
    always_comb begin
        req_legal = 1'b0;
        case (ld_funct3)
            3'b000, 3'b100: req_legal = 1'b1;
            3'b001, 3'b101: req_legal = (ld_addr[1:0] != 2'b11);
            3'b010:         req_legal = (ld_addr[1:0] == 2'b00);
            default:        req_legal = 1'b0;
        endcase
    end

    // Select and sign/zero-extend the addressed field of the response word.
    always_comb begin
        load_result = mem_rdata;
        case (funct3_q)
            3'b000:  load_result = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_result = {24'd0, byte_sel};
            3'b001:  load_result = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_result = {16'd0, half_sel};
            default: load_result = mem_rdata;
        endcase
    end

    // Next-state and output logic of the load sequencer.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        funct3_d       = funct3_q;
        rd_d           = rd_q;
        count_d        = count_q;
        data_d         = data_q;
        wb_rd_d        = wb_rd_q;
        ld_ready       = 1'b0;
        mem_req        = 1'b0;
        wb_valid       = 1'b0;
        stall          = 1'b0;
        exc_misaligned = 1'b0;
        exc_fault      = 1'b0;
        case (state_q)
            S_IDLE: begin
                ld_ready = 1'b1;
                stall    = ld_valid;
                if (ld_valid) begin
                    addr_d   = ld_addr;
                    funct3_d = ld_funct3;
                    rd_d     = ld_rd;
                    state_d  = req_legal ? S_REQ : S_ERR;
                end
            end
            S_ERR: begin
                exc_misaligned = 1'b1;
                stall          = 1'b1;
                state_d        = S_IDLE;
            end
            S_REQ: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                if (mem_gnt) begin
                    count_d = 8'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                stall   = 1'b1;
                count_d = count_q + 8'd1;
                // Data arriving on the terminal count takes priority over the fault.
                if (mem_rvalid) begin
                    data_d  = load_result;
                    wb_rd_d = rd_q;
                    state_d = S_RESP;
                end else if (count_q == LAST_COUNT) begin
                    exc_fault = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_RESP: begin
                wb_valid = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any outstanding load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            funct3_q <= 3'd0;
            rd_q     <= 5'd0;
            count_q  <= 8'd0;
            data_q   <= 32'd0;
            wb_rd_q  <= 5'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            rd_q     <= rd_d;
            count_q  <= count_d;
            data_q   <= data_d;
            wb_rd_q  <= wb_rd_d;
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// Testbench for load_align_unit: directed cases plus randomized loads.
// Every cycle is checked against expectations derived from a transaction-level model.
module tb_load_align_unit;

    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [2:0]        ld_funct3;
    logic [4:0]        ld_rd;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              wb_valid;
    logic [31:0]       wb_data;
    logic [4:0]        wb_rd;
    logic              stall;
    logic              exc_misaligned;
    logic              exc_fault;

    load_align_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_addr        (ld_addr),
        .ld_funct3      (ld_funct3),
        .ld_rd          (ld_rd),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .wb_valid       (wb_valid),
        .wb_data        (wb_data),
        .wb_rd          (wb_rd),
        .stall          (stall),
        .exc_misaligned (exc_misaligned),
        .exc_fault      (exc_fault)
    );

    always #5 clk = ~clk;

    // Expected outputs for the current cycle, maintained by the stimulus process.
    logic        e_chk;
    logic        e_ld_ready, e_mem_req, e_wb_valid, e_stall, e_mis, e_fault;
    logic [31:0] e_mem_addr;
    logic [31:0] e_wb_data;
    logic [4:0]  e_wb_rd;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Single compare process: sample all outputs mid-cycle.
    always @(negedge clk) begin
        if (e_chk) begin
            chk("ld_ready",       32'(ld_ready),       32'(e_ld_ready));
            chk("mem_req",        32'(mem_req),        32'(e_mem_req));
            chk("wb_valid",       32'(wb_valid),       32'(e_wb_valid));
            chk("stall",          32'(stall),          32'(e_stall));
            chk("exc_misaligned", 32'(exc_misaligned), 32'(e_mis));
            chk("exc_fault",      32'(exc_fault),      32'(e_fault));
            chk("wb_data",        wb_data,             e_wb_data);
            chk("wb_rd",          32'(wb_rd),          32'(e_wb_rd));
            if (e_mem_req) chk("mem_addr", mem_addr, e_mem_addr);
        end
    end

    // Reference model: architectural load result from the rules of the ISA.
    function automatic logic [31:0] model_data(input logic [31:0] addr, input logic [2:0] f3,
                                               input logic [31:0] rdata);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = rdata >> (8 * int'(addr[1:0]));
        b  = sh[7:0];
        h  = sh[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return rdata;
        endcase
    endfunction

    function automatic bit model_legal(input logic [31:0] addr, input logic [2:0] f3);
        int off;
        off = int'(addr[1:0]);
        case (f3)
            3'b000, 3'b100: return 1'b1;
            3'b001, 3'b101: return off != 3;
            3'b010:         return off == 0;
            default:        return 1'b0;
        endcase
    endfunction

    task automatic expect_o(input logic rdy, input logic req, input logic wbv,
                            input logic stl, input logic mis, input logic flt);
        e_ld_ready = rdy;
        e_mem_req  = req;
        e_wb_valid = wbv;
        e_stall    = stl;
        e_mis      = mis;
        e_fault    = flt;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Idle cycles with stray, to-be-ignored memory handshakes.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            ld_valid   = 1'b0;
            ld_addr    = $urandom;
            mem_gnt    = 1'($urandom_range(0, 1));
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
            expect_o(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc();
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    // One complete load. g: cycles of gnt delay; r: WAIT cycle (1-based) of rvalid,
    // r > TIMEOUT means no response. When use_lit is set, lit is the required result.
    task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] rdata, input int g, input int r,
                           input logic use_lit, input logic [31:0] lit);
        logic [31:0] exp_data;
        exp_data = use_lit ? lit : model_data(addr, f3, rdata);
        $display("load addr=%h f3=%0d rd=%0d rdata=%h gnt_delay=%0d rvalid_at=%0d exp=%h legal=%0d",
                 addr, f3, rd, rdata, g, r, exp_data, model_legal(addr, f3));
        // accept cycle
        ld_valid   = 1'b1;
        ld_addr    = addr;
        ld_funct3  = f3;
        ld_rd      = rd;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
        expect_o(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        // requests offered while busy must be ignored
        ld_valid  = 1'($urandom_range(0, 1));
        ld_addr   = $urandom;
        ld_funct3 = 3'($urandom);
        ld_rd     = 5'($urandom);
        if (!model_legal(addr, f3)) begin
            mem_rvalid = 1'($urandom_range(0, 1));
            expect_o(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            cyc();
        end else begin
            e_mem_addr = {addr[31:2], 2'b00};
            for (int k = 0; k <= g; k++) begin
                mem_gnt    = (k == g);
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata  = $urandom;
                expect_o(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
                cyc();
            end
            mem_gnt = 1'b0;
            for (int j = 1; j <= TIMEOUT; j++) begin
                mem_rvalid = (j == r);
                mem_rdata  = (j == r) ? rdata : $urandom;
                expect_o(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, (j == TIMEOUT) && (r > TIMEOUT));
                cyc();
                if (j == r) break;
            end
            mem_rvalid = 1'b0;
            if (r <= TIMEOUT) begin
                e_wb_data = exp_data;
                e_wb_rd   = rd;
                expect_o(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                mem_rvalid = 1'($urandom_range(0, 1));
                cyc();
            end
        end
        ld_valid   = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        e_chk      = 1'b0;
        e_mem_addr = 32'd0;
        e_wb_data  = 32'd0;
        e_wb_rd    = 5'd0;
        expect_o(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n      = 1'b0;
        ld_valid   = 1'b0;
        ld_addr    = 32'd0;
        ld_funct3  = 3'd0;
        ld_rd      = 5'd0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        cyc();
        // reset state
        e_chk = 1'b1;
        cyc();
        rst_n = 1'b1;
        idle_cycles(2);

        // hand-computed results
        do_load(32'h0000_0103, 3'b000, 5'd1, 32'h80FF_1234, 0, 1, 1'b1, 32'hFFFF_FF80);
        do_load(32'h0000_0103, 3'b100, 5'd2, 32'h80FF_1234, 0, 1, 1'b1, 32'h0000_0080);
        do_load(32'h0000_2001, 3'b001, 5'd3, 32'h1287_6534, 1, 2, 1'b1, 32'hFFFF_8765);
        do_load(32'h0000_2001, 3'b101, 5'd4, 32'h1287_6534, 0, 3, 1'b1, 32'h0000_8765);
        do_load(32'h0000_4000, 3'b010, 5'd5, 32'hDEAD_BEEF, 2, 1, 1'b1, 32'hDEAD_BEEF);
        idle_cycles(1);
        // misaligned / illegal
        do_load(32'h0000_1002, 3'b010, 5'd6, 32'd0, 0, 1, 1'b1, 32'd0);
        do_load(32'h0000_1003, 3'b001, 5'd7, 32'd0, 0, 1, 1'b1, 32'd0);
        do_load(32'h0000_1000, 3'b011, 5'd8, 32'd0, 0, 1, 1'b1, 32'd0);
        idle_cycles(1);
        // delayed grant: request held 4 cycles, data 2 cycles after grant
        do_load(32'h0000_1002, 3'b101, 5'd9, 32'hBEEF_0000, 3, 2, 1'b1, 32'h0000_BEEF);
        // data on the terminal count wins; then no response at all gives a fault
        do_load(32'h0000_5002, 3'b000, 5'd10, 32'h0081_0000, 0, TIMEOUT, 1'b1, 32'hFFFF_FF81);
        do_load(32'h0000_6000, 3'b010, 5'd11, 32'h1111_1111, 1, TIMEOUT + 1, 1'b1, 32'd0);
        idle_cycles(1);

        // reset in the middle of WAIT, then a late response
        $display("reset during WAIT");
        ld_valid  = 1'b1;
        ld_addr   = 32'h0000_3000;
        ld_funct3 = 3'b010;
        ld_rd     = 5'd12;
        expect_o(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        ld_valid   = 1'b0;
        mem_gnt    = 1'b1;
        e_mem_addr = 32'h0000_3000;
        expect_o(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        mem_gnt = 1'b0;
        rst_n   = 1'b0;
        expect_o(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        e_wb_data  = 32'd0;
        e_wb_rd    = 5'd0;
        expect_o(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        cyc();
        mem_rvalid = 1'b0;
        idle_cycles(1);

        // randomized loads against the model
        for (int n = 0; n < 250; n++) begin
            logic [31:0] a;
            logic [2:0]  f;
            a = $urandom;
            f = 3'($urandom_range(0, 7));
            do_load(a, f, 5'($urandom), $urandom, $urandom_range(0, 3),
                    $urandom_range(1, TIMEOUT + 1), 1'b0, 32'd0);
            idle_cycles($urandom_range(0, 2));
        end

        e_chk = 1'b0;
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
